cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
Exception/interrupt controller (minimal CP0) that sequences the PC select logic of the single-cycle core. Holds SR, Cause and EPC. Arbitrates synchronous exceptions against masked external interrupts. Drives the has_exp/epc/handler_pc controls consumed by pc_module, and tracks handler entry and exit through ERET.

Parameters:
NUM_IRQ, 6, number of external interrupt lines (1..6), mapped to IP/IM bits [9+NUM_IRQ:10]
HANDLER_ADDR, 32'h00004180, exception vector driven on handler_pc

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
irq_i  in  NUM_IRQ  level-sensitive external interrupt lines
cur_pc  in  32  PC of the instruction executing this cycle
sync_exc  in  1  current instruction raised a synchronous exception (syscall, overflow, ...)
sync_code  in  5  ExcCode for sync_exc
is_eret  in  1  current instruction is ERET
is_mtc0  in  1  current instruction writes CP0
cp0_addr  in  5  CP0 register index (12 SR, 13 Cause, 14 EPC)
cp0_wdata  in  32  MTC0 write data
cp0_rdata  out  32  combinational MFC0 read of cp0_addr; unmapped indexes read 0
has_exp  out  1  redirect next PC to handler_pc; core suppresses this instruction's writes
epc  out  32  EPC register, ERET target
handler_pc  out  32  constant HANDLER_ADDR
exl  out  1  SR.EXL; 1 = in handler

Behaviour:
- Registers:
  - SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause: IP=[15:10] read-only, ExcCode=[6:2].
  - EPC: full 32 bits.
  - Reset (async, rst_n=0): SR=0, Cause=0, EPC=0, irq_q=0. Outputs then: has_exp=0, epc=0, exl=0.
- IRQ sampling: irq_q <= irq_i every cycle. IP = irq_q, so there is 1 cycle of latency from irq_i to IP. IP is level, not sticky.
- int_req = |(IP & IM) & IE & ~EXL.
- FSM has 2 states encoded by EXL: RUN (EXL=0) and HANDLER (EXL=1).
- has_exp = sync_exc | int_req. It is combinational and asserts in the same cycle.
- Priority: sync_exc beats int_req. ExcCode = sync_code for a sync exception, 0 for an interrupt.
- On the clock edge where has_exp=1:
  - From RUN: EPC<=cur_pc, ExcCode updated, EXL<=1, next state HANDLER.
  - From HANDLER (sync_exc only, since int_req is blocked): EPC unchanged, ExcCode updated, EXL stays 1.
- ERET (is_eret=1, has_exp=0): EXL<=0, next state RUN. The ERET target is epc (selected by pc_module). ERET while in RUN makes no CP0 change.
- MTC0 (is_mtc0=1, has_exp=0):
  - SR: writes IM/EXL/IE. Writing EXL moves the FSM.
  - Cause: writes ExcCode only.
  - EPC: writes all 32 bits.
  - Other indexes: ignored.
- Simultaneous events, resolved in this order:
  - sync_exc > ERET > MTC0; a dropped ERET or MTC0 has no effect.
  - int_req with ERET/MTC0 in the same cycle: interrupt taken, other op dropped.
  - MTC0 setting IE=1 affects int_req from the next cycle only.
- cp0_rdata reflects register values before the current edge (no write-through bypass).
- Reset asserted mid-handler clears EXL immediately (asynchronously) and returns to RUN.

Optional Feature:
CP0_TIMER_EN
- Defined:
  - Adds Count (index 9), incremented every cycle and wrapping at 2^32.
  - Adds Compare (index 11).
  - When Count==Compare, sticky Cause.TI (bit 30) sets. Writing Compare clears TI.
  - SR bit 16 (TM) masks the timer.
  - int_req additionally includes TI & TM (gated by IE & ~EXL).
  - MTC0 to Count loads it; the load takes priority over the increment.
  - Reset: Count=0, Compare=32'hFFFFFFFF, TI=0, TM=0.
- Undefined: indexes 9/11 read 0, Cause[30]=0, SR[16]=0, no timer logic.

Test Plan:
- Reset: rst_n=0 mid-cycle with EXL=1 -> exl=0, epc=0, has_exp=0 immediately, cp0_rdata(12)=0.
- Sync exception: cur_pc=32'h00400010, sync_exc=1, sync_code=8 -> has_exp=1 the same cycle; after the edge epc=32'h00400010, Cause[6:2]=8, exl=1. Then is_eret=1 -> exl=0, epc unchanged.
- Masked/enabled IRQ:
  - SR=32'h00000401 (IM0, IE); irq_i[0]=1 at cycle N -> has_exp=1 at N+1, ExcCode=0, epc=cur_pc at N+1.
  - Same with IE=0 -> has_exp stays 0.
- Nested: in HANDLER, irq_i asserted -> no has_exp. sync_exc with code 12 -> has_exp=1, EPC unchanged, ExcCode=12.
- Collision: sync_exc, is_eret and is_mtc0 (EPC<=32'hDEAD0000) in the same cycle -> exception taken, EPC=cur_pc, EXL=1, MTC0 dropped.
- CP0_TIMER_EN: Compare=5, TM=1, IE=1, Count=0 -> TI=1 after Count reaches 5 (the 6th edge counting the Compare write), has_exp the next cycle. Writing Compare clears TI.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// Minimal CP0: SR/Cause/EPC, exception/interrupt arbitration and handler entry/exit for the PC select logic.
// Optional timer (Count/Compare, Cause.TI, SR.TM) is built when CP0_TIMER_EN is defined.
module cp0_exc_ctrl #(
  parameter int          NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h00004180
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        cur_pc,
  input  logic               sync_exc,
  input  logic [4:0]         sync_code,
  input  logic               is_eret,
  input  logic               is_mtc0,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               has_exp,
  output logic [31:0]        epc,
  output logic [31:0]        handler_pc,
  output logic               exl
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] HANDLER = 1'b1;

  localparam logic [4:0] COUNT_IDX   = 5'd9;
  localparam logic [4:0] COMPARE_IDX = 5'd11;
  localparam logic [4:0] SR_IDX      = 5'd12;
  localparam logic [4:0] CAUSE_IDX   = 5'd13;
  localparam logic [4:0] EPC_IDX     = 5'd14;

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] im;
  logic               ie;
  logic [0:0]         state;
  logic [4:0]         exc_code;
  logic [31:0]        epc_q;
  logic               int_req;
  logic               timer_int;
  logic               mtc0_en;

  // Place an IRQ-width field at IP/IM position [9+NUM_IRQ:10] of a 32-bit word.
  function automatic logic [31:0] irq_field(input logic [NUM_IRQ-1:0] bits);
    logic [31:0] w;
    w = '0;
    w[9+NUM_IRQ:10] = bits;
    return w;
  endfunction

  assign int_req    = ((|(irq_q & im)) | timer_int) & ie & (state == RUN);
  assign has_exp    = sync_exc | int_req;
  assign mtc0_en    = is_mtc0 & ~has_exp;
  assign epc        = epc_q;
  assign exl        = state[0];
  assign handler_pc = HANDLER_ADDR;

  // Priority: exception/interrupt > ERET > MTC0; the losers are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= '0;
      im       <= '0;
      ie       <= 1'b0;
      state    <= RUN;
      exc_code <= '0;
      epc_q    <= '0;
    end else begin
      irq_q <= irq_i;
      if (has_exp) begin
        exc_code <= sync_exc ? sync_code : 5'd0;
        if (state == RUN) begin
          epc_q <= cur_pc;
          state <= HANDLER;
        end
      end else if (is_eret) begin
        state <= RUN;
      end else if (is_mtc0) begin
        case (cp0_addr)
          SR_IDX: begin
            im    <= cp0_wdata[9+NUM_IRQ:10];
            state <= cp0_wdata[1:1];
            ie    <= cp0_wdata[0];
          end
          CAUSE_IDX: exc_code <= cp0_wdata[6:2];
          EPC_IDX:   epc_q    <= cp0_wdata;
          default:   ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti;
  logic        tm;

  // A Count load wins over the increment; a Compare write wins over a match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      ti        <= 1'b0;
      tm        <= 1'b0;
    end else begin
      if (mtc0_en && cp0_addr == COUNT_IDX) count_q <= cp0_wdata;
      else                                  count_q <= count_q + 32'd1;
      if (mtc0_en && cp0_addr == COMPARE_IDX) begin
        compare_q <= cp0_wdata;
        ti        <= 1'b0;
      end else if (count_q == compare_q) begin
        ti <= 1'b1;
      end
      if (mtc0_en && cp0_addr == SR_IDX) tm <= cp0_wdata[16];
    end
  end

  assign timer_int = ti & tm;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      COUNT_IDX:   cp0_rdata = count_q;
      COMPARE_IDX: cp0_rdata = compare_q;
      SR_IDX:      cp0_rdata = irq_field(im) | {15'd0, tm, 14'd0, state, ie};
      CAUSE_IDX:   cp0_rdata = irq_field(irq_q) | {1'b0, ti, 23'd0, exc_code, 2'b00};
      EPC_IDX:     cp0_rdata = epc_q;
      default:     cp0_rdata = '0;
    endcase
  end
`else
  assign timer_int = 1'b0;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      SR_IDX:    cp0_rdata = irq_field(im) | {30'd0, state, ie};
      CAUSE_IDX: cp0_rdata = irq_field(irq_q) | {25'd0, exc_code, 2'b00};
      EPC_IDX:   cp0_rdata = epc_q;
      default:   cp0_rdata = '0;
    endcase
  end
`endif

endmodule
